// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, FSM state and MEM/WB control/trace bundle for mem_stage
package mem_stage_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_REG_W = 5;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef struct packed {
    logic        regwrite;
    logic        mem2reg;
    logic [31:0] instr;
    logic [31:0] pc;
  } wb_ctl_t;
endpackage

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: one-outstanding data-memory request/ack handshake, request register and stall
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              issue,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  dest,
  input  wb_ctl_t           ctl,
  input  logic              DMEM_ACK,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  output logic              STALL,
  output logic              busy,
  output logic [REG_W-1:0]  req_dest,
  output wb_ctl_t           req_ctl
);
  state_t state, next_state;
  assign busy = state == ACCESS;
  assign DMEM_REQ = busy;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) state <= IDLE;
    else state <= next_state;
  // request register doubles as the DMEM drive, so it stays stable until ack
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= '0;
      req_dest   <= '0;
      req_ctl    <= '0;
    end else if (state == IDLE && issue) begin
      DMEM_WE    <= we;
      DMEM_ADDR  <= addr;
      DMEM_WDATA <= wdata;
      req_dest   <= dest;
      req_ctl    <= ctl;
    end
  always_comb begin
    next_state = state;
    STALL = 1'b0;
    case (state)
      IDLE: begin
        next_state = issue ? ACCESS : IDLE;
        STALL = RESET & issue;
      end
      ACCESS: begin
        next_state = DMEM_ACK ? IDLE : ACCESS;
        STALL = RESET & ~DMEM_ACK;
      end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with MEM/WB register and CBZ resolve; MEM_ALIGN_CHECK_EN adds ALIGN_FAULT
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] ALU_VAL_IN,
  input  logic [DATA_W-1:0] RT_READ_IN,
  input  logic [DATA_W-1:0] BRANCH_IN,
  input  logic              ZERO_IN,
  input  logic              BRANCH_ZERO_IN,
  input  logic              MEMREAD_IN,
  input  logic              MEMWRITE_IN,
  input  logic              MEM2REG_IN,
  input  logic              REGWRITE_IN,
  input  logic [REG_W-1:0]  REG_DESTINATION_IN,
  input  logic [31:0]       INSTR_IN,
  input  logic [31:0]       PC_IN,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              STALL,
  output logic              PCSRC,
  output logic [DATA_W-1:0] BRANCH_TARGET,
  output logic [DATA_W-1:0] READ_DATA_OUT,
  output logic [DATA_W-1:0] ALU_VAL_OUT,
  output logic [REG_W-1:0]  REG_DESTINATION_OUT,
  output logic              REGWRITE_OUT,
  output logic              MEM2REG_OUT,
  output logic              WB_VALID,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              ALIGN_FAULT,
`endif
  output logic [31:0]       INSTR_OUT,
  output logic [31:0]       PC_OUT
);
  logic mem_op, issue, busy, bubble;
  logic [REG_W-1:0] req_dest;
  wb_ctl_t in_ctl, req_ctl;
  assign mem_op = MEMREAD_IN | MEMWRITE_IN;
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = mem_op & |ALU_VAL_IN[2:0];
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) ALIGN_FAULT <= 1'b0;
    else ALIGN_FAULT <= ~busy & misalign;
`else
  localparam logic misalign = 1'b0;
`endif
  assign issue = mem_op & ~misalign;
  assign in_ctl = '{regwrite: REGWRITE_IN, mem2reg: MEM2REG_IN, instr: INSTR_IN, pc: PC_IN};
  assign bubble = busy ? ~DMEM_ACK : issue;
  assign PCSRC = RESET & ~STALL & BRANCH_ZERO_IN & ZERO_IN;
  assign BRANCH_TARGET = BRANCH_IN;
  mem_access_fsm #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fsm (
    .CLK(CLK),
    .RESET(RESET),
    .issue(issue),
    .we(MEMWRITE_IN),
    .addr(ALU_VAL_IN),
    .wdata(RT_READ_IN),
    .dest(REG_DESTINATION_IN),
    .ctl(in_ctl),
    .DMEM_ACK(DMEM_ACK),
    .DMEM_REQ(DMEM_REQ),
    .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA),
    .STALL(STALL),
    .busy(busy),
    .req_dest(req_dest),
    .req_ctl(req_ctl)
  );
  // in ACCESS the live inputs are ignored; the completed access comes from the request register
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      READ_DATA_OUT       <= '0;
      ALU_VAL_OUT         <= '0;
      REG_DESTINATION_OUT <= '0;
      REGWRITE_OUT        <= 1'b0;
      MEM2REG_OUT         <= 1'b0;
      WB_VALID            <= 1'b0;
      INSTR_OUT           <= '0;
      PC_OUT              <= '0;
    end else if (bubble) begin
      REGWRITE_OUT <= 1'b0;
      WB_VALID     <= 1'b0;
    end else begin
      READ_DATA_OUT       <= (busy & ~DMEM_WE) ? DMEM_RDATA : '0;
      ALU_VAL_OUT         <= busy ? DMEM_ADDR : ALU_VAL_IN;
      REG_DESTINATION_OUT <= busy ? req_dest : REG_DESTINATION_IN;
      REGWRITE_OUT        <= busy ? req_ctl.regwrite : REGWRITE_IN & ~misalign;
      MEM2REG_OUT         <= busy ? req_ctl.mem2reg : MEM2REG_IN;
      INSTR_OUT           <= busy ? req_ctl.instr : INSTR_IN;
      PC_OUT              <= busy ? req_ctl.pc : PC_IN;
      WB_VALID            <= 1'b1;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level check of mem_stage against a reference model
module tb_mem_stage;
  logic CLK = 1'b0, RESET;
  logic [63:0] ALU_VAL_IN, RT_READ_IN, BRANCH_IN, DMEM_RDATA;
  logic ZERO_IN, BRANCH_ZERO_IN, MEMREAD_IN, MEMWRITE_IN, MEM2REG_IN, REGWRITE_IN, DMEM_ACK;
  logic [4:0] REG_DESTINATION_IN;
  logic [31:0] INSTR_IN, PC_IN;
  logic DMEM_REQ, DMEM_WE, STALL, PCSRC, REGWRITE_OUT, MEM2REG_OUT, WB_VALID;
  logic [63:0] DMEM_ADDR, DMEM_WDATA, BRANCH_TARGET, READ_DATA_OUT, ALU_VAL_OUT;
  logic [4:0] REG_DESTINATION_OUT;
  logic [31:0] INSTR_OUT, PC_OUT;
`ifdef MEM_ALIGN_CHECK_EN
  logic ALIGN_FAULT;
`endif
  int n_checks = 0, n_errors = 0;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VAL_IN(ALU_VAL_IN), .RT_READ_IN(RT_READ_IN), .BRANCH_IN(BRANCH_IN),
    .ZERO_IN(ZERO_IN), .BRANCH_ZERO_IN(BRANCH_ZERO_IN),
    .MEMREAD_IN(MEMREAD_IN), .MEMWRITE_IN(MEMWRITE_IN), .MEM2REG_IN(MEM2REG_IN), .REGWRITE_IN(REGWRITE_IN),
    .REG_DESTINATION_IN(REG_DESTINATION_IN), .INSTR_IN(INSTR_IN), .PC_IN(PC_IN),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .STALL(STALL), .PCSRC(PCSRC), .BRANCH_TARGET(BRANCH_TARGET),
    .READ_DATA_OUT(READ_DATA_OUT), .ALU_VAL_OUT(ALU_VAL_OUT), .REG_DESTINATION_OUT(REG_DESTINATION_OUT),
    .REGWRITE_OUT(REGWRITE_OUT), .MEM2REG_OUT(MEM2REG_OUT), .WB_VALID(WB_VALID),
`ifdef MEM_ALIGN_CHECK_EN
    .ALIGN_FAULT(ALIGN_FAULT),
`endif
    .INSTR_OUT(INSTR_OUT), .PC_OUT(PC_OUT)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // one instruction through the stage; memory answers after w ACCESS cycles with rdata
  task automatic run_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic bz, input logic z, input logic [63:0] alu, input logic [63:0] rt,
                        input logic [63:0] br, input logic [4:0] dst, input int w, input logic [63:0] rdata);
    logic mem;
    logic [31:0] ins, pc;
    int stalls;
    mem = rd | wr;
    ins = $urandom;
    pc = $urandom;
    stalls = 0;
    MEMREAD_IN = rd; MEMWRITE_IN = wr; MEM2REG_IN = m2r; REGWRITE_IN = rw;
    BRANCH_ZERO_IN = bz; ZERO_IN = z; ALU_VAL_IN = alu; RT_READ_IN = rt; BRANCH_IN = br;
    REG_DESTINATION_IN = dst; INSTR_IN = ins; PC_IN = pc;
    DMEM_ACK = mem ? 1'b0 : 1'($urandom_range(0, 1));
    DMEM_RDATA = rnd64();
    #1;
    check("stall_first", 64'(STALL), 64'(mem));
    check("req_first", 64'(DMEM_REQ), 64'd0);
    check("pcsrc_first", 64'(PCSRC), mem ? 64'd0 : 64'(bz & z));
    check("branch_target", BRANCH_TARGET, br);
    stalls += int'(STALL);
    @(posedge CLK); #1;
    if (mem) begin
      check("bubble_valid", 64'(WB_VALID), 64'd0);
      check("bubble_regwrite", 64'(REGWRITE_OUT), 64'd0);
      ALU_VAL_IN = rnd64(); RT_READ_IN = rnd64(); REG_DESTINATION_IN = 5'($urandom);
      INSTR_IN = $urandom; PC_IN = $urandom;
      for (int k = 0; k <= w; k++) begin
        DMEM_ACK = (k == w);
        DMEM_RDATA = (k == w) ? rdata : rnd64();
        #1;
        check("dmem_req", 64'(DMEM_REQ), 64'd1);
        check("dmem_addr", DMEM_ADDR, alu);
        check("dmem_wdata", DMEM_WDATA, rt);
        check("dmem_we", 64'(DMEM_WE), 64'(wr));
        check("pcsrc_access", 64'(PCSRC), (k == w) ? 64'(bz & z) : 64'd0);
        stalls += int'(STALL);
        @(posedge CLK); #1;
        if (k < w) check("wait_bubble", 64'(WB_VALID), 64'd0);
      end
      DMEM_ACK = 1'b0;
      check("stall_cycles", 64'(stalls), 64'(w + 1));
      check("req_after", 64'(DMEM_REQ), 64'd0);
    end
    check("alu_out", ALU_VAL_OUT, alu);
    check("read_data", READ_DATA_OUT, (rd & ~wr) ? rdata : 64'd0);
    check("dest_out", 64'(REG_DESTINATION_OUT), 64'(dst));
    check("regwrite_out", 64'(REGWRITE_OUT), 64'(rw));
    check("mem2reg_out", 64'(MEM2REG_OUT), 64'(m2r));
    check("wb_valid", 64'(WB_VALID), 64'd1);
    check("instr_out", 64'(INSTR_OUT), 64'(ins));
    check("pc_out", 64'(PC_OUT), 64'(pc));
`ifdef MEM_ALIGN_CHECK_EN
    check("no_fault", 64'(ALIGN_FAULT), 64'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0;
    {ALU_VAL_IN, RT_READ_IN, BRANCH_IN, DMEM_RDATA} = '0;
    {ZERO_IN, BRANCH_ZERO_IN, MEMREAD_IN, MEMWRITE_IN, MEM2REG_IN, REGWRITE_IN, DMEM_ACK} = '0;
    REG_DESTINATION_IN = '0; INSTR_IN = '0; PC_IN = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", 64'(WB_VALID), 64'd0);
    check("rst_req", 64'(DMEM_REQ), 64'd0);
    check("rst_stall", 64'(STALL), 64'd0);
    check("rst_read", READ_DATA_OUT, 64'd0);
    RESET = 1'b1;
    run_op(0, 0, 0, 1, 0, 0, 64'h10, rnd64(), rnd64(), 5'd3, 0, 64'd0);
    run_op(1, 0, 1, 1, 0, 0, 64'h40, rnd64(), rnd64(), 5'd7, 3, 64'hDEADBEEF);
    run_op(0, 1, 0, 0, 0, 0, 64'h80, 64'h1234, rnd64(), 5'd0, 0, rnd64());
    run_op(0, 0, 0, 0, 1, 1, rnd64(), rnd64(), 64'h200, 5'd0, 0, 64'd0);
    run_op(1, 0, 1, 1, 1, 1, 64'h88, rnd64(), 64'h200, 5'd9, 2, rnd64());
    run_op(1, 1, 0, 1, 0, 0, 64'h90, rnd64(), rnd64(), 5'd4, 1, rnd64());
    // reset mid-access, then a stale ack under reset
    MEMREAD_IN = 1; MEMWRITE_IN = 0; ALU_VAL_IN = 64'h100; BRANCH_ZERO_IN = 1; ZERO_IN = 1;
    @(posedge CLK); #1;
    check("mid_req", 64'(DMEM_REQ), 64'd1);
    RESET = 1'b0;
    #1;
    check("mid_rst_req", 64'(DMEM_REQ), 64'd0);
    check("mid_rst_stall", 64'(STALL), 64'd0);
    check("mid_rst_pcsrc", 64'(PCSRC), 64'd0);
    check("mid_rst_addr", DMEM_ADDR, 64'd0);
    check("mid_rst_valid", 64'(WB_VALID), 64'd0);
    check("mid_rst_alu", ALU_VAL_OUT, 64'd0);
    DMEM_ACK = 1'b1; DMEM_RDATA = rnd64();
    @(posedge CLK); #1;
    check("late_ack_valid", 64'(WB_VALID), 64'd0);
    check("late_ack_read", READ_DATA_OUT, 64'd0);
    check("late_ack_req", 64'(DMEM_REQ), 64'd0);
    DMEM_ACK = 1'b0; MEMREAD_IN = 0; BRANCH_ZERO_IN = 0; ZERO_IN = 0;
    RESET = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
    MEMREAD_IN = 1; REGWRITE_IN = 1; ALU_VAL_IN = 64'h43;
    #1;
    check("align_stall", 64'(STALL), 64'd0);
    check("align_req", 64'(DMEM_REQ), 64'd0);
    @(posedge CLK); #1;
    check("align_fault", 64'(ALIGN_FAULT), 64'd1);
    check("align_regwrite", 64'(REGWRITE_OUT), 64'd0);
    check("align_valid", 64'(WB_VALID), 64'd1);
    check("align_noreq", 64'(DMEM_REQ), 64'd0);
    MEMREAD_IN = 0;
    @(posedge CLK); #1;
    check("align_clear", 64'(ALIGN_FAULT), 64'd0);
`endif
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a;
      a = rnd64();
`ifdef MEM_ALIGN_CHECK_EN
      a[2:0] = 3'd0;
`endif
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             a, rnd64(), rnd64(), 5'($urandom), int'($urandom_range(0, 4)), rnd64());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
